irrigacao_multizona: RTL and testbench
======================================

# irrigacao_multizona

Multi-zone irrigation executor that turns per-zone pump-time commands (ms, as produced by the per-plant catalogue/compensation logic of `sistema_irrigacao`) into actual valve and pump drive. It generalises the single-channel, purely computed `cmd_tempo_bomba_ms` path to N zones sharing one pump and one reservoir. It queues one request per zone, serves zones round-robin, sequences valve-open before pump-on, counts real milliseconds, and pauses on low reservoir level with hysteresis.

## Interface
- `N_ZONAS`, 4: number of zones (2..16).
- `TEMPO_W`, 16: width of a pump-time request in ms.
- `CICLOS_MS`, 50000: clock cycles per ms (50 MHz).
- `T_ABRE_MS`, 20: valve settle time before the pump starts, in ms (≥1).
- `NIVEL_MIN`, 20: level below which the low-level alert sets.
- `NIVEL_RETOMA`, 30: level at or above which the alert clears (> `NIVEL_MIN`).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_ZONAS: per-zone request strobe.
- `req_tempo_ms` in N_ZONAS*TEMPO_W: packed per-zone pump time; zone i is bits [i*TEMPO_W +: TEMPO_W].
- `req_ready` out N_ZONAS: zone can accept a request.
- `sensor_nivel` in 8: reservoir level.
- `parar` in 1: abort the active zone.
- `valvula` out N_ZONAS: one-hot valve drive.
- `bomba_on` out 1: pump drive.
- `zona_ativa` out clog2(N_ZONAS): index of the served zone; 0 when idle.
- `tempo_restante_ms` out TEMPO_W: remaining pump ms of the active zone.
- `ocupado` out 1: FSM not in IDLE.
- `done` out N_ZONAS: one-cycle completion pulse per zone.
- `alerta_nivel_baixo` out 1: registered low-level alert.

## Operation
- Per-zone `pendente[i]` flag and `tempo[i]` register. `req_ready[i] = !pendente[i] && !(ocupado && zona_ativa==i)`.
- Accept on `req_valid[i] && req_ready[i]`. If the tempo is nonzero, latch it and set `pendente[i]`. If the tempo is 0, ignore it: nothing is latched and no `done` pulse is produced.
- Alert register, updated every cycle:
  - `nivel < NIVEL_MIN` → 1.
  - else if `nivel >= NIVEL_RETOMA` → 0.
  - else hold.
- Round-robin pointer `ptr`, reset 0.
- FSM states:
  - **IDLE**: if `!alerta` and any `pendente` are set, grant the first pending zone scanning from `ptr` upward with wrap. Set `ptr ← winner+1 mod N`, clear `pendente[winner]`, load `tempo_restante_ms`, go to ABRE.
  - **ABRE**: `valvula[winner]` = 1, pump off. After `T_ABRE_MS` ms ticks, go to BOMBEANDO.
  - **BOMBEANDO**: valve and pump on. Each ms tick decrements `tempo_restante_ms`.
    - Reaching 0 → IDLE with a `done[winner]` pulse.
    - `alerta` = 1 → PAUSA.
  - **PAUSA**: pump off, valve held, remaining time frozen. When `alerta` = 0, go to BOMBEANDO.
- `parar` in any non-IDLE state → IDLE next edge. Valve and pump go off, there is no `done` pulse, and other zones' `pendente` flags are retained. `parar` in IDLE has no effect.
- The ms prescaler counts 0..CICLOS_MS-1 and is cleared on every state entry. The first tick in a state therefore occurs exactly `CICLOS_MS` cycles after entry.
- A partially elapsed ms before PAUSA is discarded; after resume, a full ms is counted.

## Timing
- All outputs are registered.
- Reset values: `valvula`=0, `bomba_on`=0, `zona_ativa`=0, `tempo_restante_ms`=0, `ocupado`=0, `done`=0, `alerta_nivel_baixo`=0, `req_ready`=all 1. Internally, `pendente`=0, `ptr`=0, state IDLE.
- `rst` mid-operation clears everything, including pending requests, on the next edge.
- Accept at edge E0. The grant occurs at edge E1, after which `valvula` and `ocupado` are high.
- `valvula` high for T_ABRE_MS·CICLOS_MS + T·CICLOS_MS cycles (no pause).
- `bomba_on` high for exactly T·CICLOS_MS cycles total, excluding PAUSA time.
- `done` pulses during the first cycle back in IDLE. A new grant can occur on the edge after that, giving a minimum 1 idle cycle between zones.
- Level reaction: alert registration takes 1 cycle and the FSM transition takes 1 cycle. `bomba_on` drops ≤2 cycles after `sensor_nivel` crosses below `NIVEL_MIN`.
- If `alerta` and the final tick coincide, completion wins and the FSM goes to IDLE with `done`.
- If `parar` and the final tick coincide, `parar` wins and there is no `done`.
- `req_valid` for the active zone during service is refused (`req_ready` low). It may be requeued after `done`.

## Test plan
Sim parameters: `CICLOS_MS`=4, `T_ABRE_MS`=1, N=4.
- **Single request**: zone 0, tempo 3 → `valvula`=0001 for 16 cycles, `bomba_on` for 12 cycles starting 4 cycles after valve, `done[0]` single pulse, `tempo_restante_ms` 3→2→1→0.
- **Fairness**: simultaneous requests on zones 1 and 3 (tempo 1) with `ptr`=0 → zone 1 then zone 3. Then requests on zones 0 and 3 → zone 0 first (`ptr`=0 after wrap), then zone 3.
- **Level hysteresis**: `nivel` 80→10 mid-pump → `bomba_on` low within 2 cycles, valve held, remaining time frozen. At 25 the pump stays off. At 35 it resumes, and total `bomba_on` cycles equal tempo·4. A pending request with `nivel`=10 in IDLE is not granted.
- **Handshake edges**: a second `req_valid` on a pending zone → `req_ready` low and the original tempo is kept. Tempo 0 → no `pendente` and no `done`.
- **Abort/reset**: `parar` during BOMBEANDO with another zone pending → outputs off, no `done`, next zone granted 1 cycle later. `rst` mid-pump → all outputs at reset values next cycle and the queue is emptied.
- **Width boundary**: tempo 0xFFFF with `CICLOS_MS`=1 → `bomba_on` for 65535 cycles, no wrap of `tempo_restante_ms`.

Source files
------------

// File: rtl/irrigacao_multizona_if.sv
// rtl/irrigacao_multizona_if.sv - per-zone request handshake for the multi-zone irrigation executor
interface irrigacao_multizona_if #(
    parameter int N_ZONAS = 4,
    parameter int TEMPO_W = 16
);
    logic [N_ZONAS-1:0]         req_valid;
    logic [N_ZONAS*TEMPO_W-1:0] req_tempo_ms;
    logic [N_ZONAS-1:0]         req_ready;

    modport master (output req_valid, output req_tempo_ms, input  req_ready);
    modport slave  (input  req_valid, input  req_tempo_ms, output req_ready);
endinterface

// File: rtl/irrigacao_multizona.sv
// rtl/irrigacao_multizona.sv - multi-zone valve/pump sequencer with round-robin service and level hysteresis
module irrigacao_multizona #(
    parameter int N_ZONAS      = 4,
    parameter int TEMPO_W      = 16,
    parameter int CICLOS_MS    = 50000,
    parameter int T_ABRE_MS    = 20,
    parameter int NIVEL_MIN    = 20,
    parameter int NIVEL_RETOMA = 30
) (
    input  logic                         clk,
    input  logic                         rst,
    irrigacao_multizona_if.slave         req,
    input  logic [7:0]                   sensor_nivel,
    input  logic                         parar,
    output logic [N_ZONAS-1:0]           valvula,
    output logic                         bomba_on,
    output logic [$clog2(N_ZONAS)-1:0]   zona_ativa,
    output logic [TEMPO_W-1:0]           tempo_restante_ms,
    output logic                         ocupado,
    output logic [N_ZONAS-1:0]           done,
    output logic                         alerta_nivel_baixo
);
    localparam int ZW = $clog2(N_ZONAS);
    localparam int PW = $clog2(CICLOS_MS + 1);
    localparam int AW = $clog2(T_ABRE_MS + 1);
    localparam logic [N_ZONAS-1:0] UM = N_ZONAS'(1);

    typedef enum logic [1:0] {IDLE, ABRE, BOMBEANDO, PAUSA} estado_t;
    estado_t estado, estado_n;

    logic [N_ZONAS-1:0] pendente;
    logic [TEMPO_W-1:0] tempo [N_ZONAS];
    logic [ZW-1:0]      ptr;
    logic [PW-1:0]      pre_cnt;
    logic [AW-1:0]      abre_cnt;
    logic               tick;
    logic               fim;
    logic               concede;
    logic               grant_ok;
    logic [ZW-1:0]      vencedor;
    logic [N_ZONAS-1:0] pronto;
    logic [N_ZONAS-1:0] aceita;
    logic [N_ZONAS-1:0] limpa;

    assign tick = (pre_cnt == PW'(CICLOS_MS - 1));
    assign fim  = (estado == BOMBEANDO) && tick && (tempo_restante_ms == TEMPO_W'(1));
    assign req.req_ready = pronto;

    // Zero-length requests are dropped at the door so they never occupy the queue.
    always_comb begin
        pronto = '0;
        aceita = '0;
        for (int i = 0; i < N_ZONAS; i++) begin
            pronto[i] = !pendente[i] && !(ocupado && zona_ativa == ZW'(i));
            aceita[i] = req.req_valid[i] && pronto[i] &&
                        (req.req_tempo_ms[i*TEMPO_W +: TEMPO_W] != '0);
        end
    end

    // Scan downward so the last hit is the first pending zone at or after ptr.
    always_comb begin
        int idx;
        grant_ok = 1'b0;
        vencedor = '0;
        idx      = 0;
        for (int k = N_ZONAS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_ZONAS) idx = idx - N_ZONAS;
            if (pendente[ZW'(idx)]) begin
                grant_ok = 1'b1;
                vencedor = ZW'(idx);
            end
        end
    end

    always_comb begin
        estado_n = estado;
        case (estado)
            IDLE:      if (!alerta_nivel_baixo && grant_ok) estado_n = ABRE;
            ABRE:      if (tick && abre_cnt == AW'(T_ABRE_MS - 1)) estado_n = BOMBEANDO;
            BOMBEANDO: if (fim) estado_n = IDLE;
                       else if (alerta_nivel_baixo) estado_n = PAUSA;
            PAUSA:     if (!alerta_nivel_baixo) estado_n = BOMBEANDO;
            default:   estado_n = IDLE;
        endcase
        if (parar && estado != IDLE) estado_n = IDLE;
        concede = (estado == IDLE) && (estado_n == ABRE);
        limpa   = concede ? (UM << vencedor) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) estado <= IDLE;
        else     estado <= estado_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pendente           <= '0;
            ptr                <= '0;
            pre_cnt            <= '0;
            abre_cnt           <= '0;
            valvula            <= '0;
            bomba_on           <= 1'b0;
            zona_ativa         <= '0;
            tempo_restante_ms  <= '0;
            ocupado            <= 1'b0;
            done               <= '0;
            alerta_nivel_baixo <= 1'b0;
            for (int i = 0; i < N_ZONAS; i++) tempo[i] <= '0;
        end else begin
            if (sensor_nivel < 8'(NIVEL_MIN))           alerta_nivel_baixo <= 1'b1;
            else if (sensor_nivel >= 8'(NIVEL_RETOMA))  alerta_nivel_baixo <= 1'b0;

            // Prescaler restarts on every state entry, so a ms interrupted by a pause is lost.
            if (estado_n != estado || tick) pre_cnt <= '0;
            else                            pre_cnt <= pre_cnt + PW'(1);
            if (estado_n != estado) abre_cnt <= '0;
            else if (tick)          abre_cnt <= abre_cnt + AW'(1);

            for (int i = 0; i < N_ZONAS; i++)
                if (aceita[i]) tempo[i] <= req.req_tempo_ms[i*TEMPO_W +: TEMPO_W];
            pendente <= (pendente | aceita) & ~limpa;
            done     <= '0;
            bomba_on <= (estado_n == BOMBEANDO);

            if (concede) begin
                ptr               <= (vencedor == ZW'(N_ZONAS - 1)) ? '0 : vencedor + ZW'(1);
                zona_ativa        <= vencedor;
                tempo_restante_ms <= tempo[vencedor];
                valvula           <= UM << vencedor;
                ocupado           <= 1'b1;
            end else if (estado != IDLE && estado_n == IDLE) begin
                valvula           <= '0;
                zona_ativa        <= '0;
                tempo_restante_ms <= '0;
                ocupado           <= 1'b0;
                if (fim && !parar) done[zona_ativa] <= 1'b1;
            end else if (estado == BOMBEANDO && tick) begin
                tempo_restante_ms <= tempo_restante_ms - TEMPO_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_irrigacao_multizona.sv
// tb/tb_irrigacao_multizona.sv - directed bench for the multi-zone irrigation executor
module tb_irrigacao_multizona;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] sensor_nivel = 8'd80;
    logic parar = 1'b0;

    logic [3:0]  valvula, done;
    logic        bomba_on, ocupado, alerta_nivel_baixo;
    logic [1:0]  zona_ativa;
    logic [15:0] tempo_restante_ms;

    logic [3:0]  valvula2, done2;
    logic        bomba2, ocupado2, alerta2;
    logic [1:0]  zona2;
    logic [15:0] rest2;

    int n_tests = 0;
    int n_fail  = 0;

    irrigacao_multizona_if #(.N_ZONAS(4), .TEMPO_W(16)) rif ();
    irrigacao_multizona_if #(.N_ZONAS(4), .TEMPO_W(16)) rif2 ();

    irrigacao_multizona #(.N_ZONAS(4), .TEMPO_W(16), .CICLOS_MS(4), .T_ABRE_MS(1),
                          .NIVEL_MIN(20), .NIVEL_RETOMA(30)) dut (
        .clk(clk), .rst(rst), .req(rif.slave), .sensor_nivel(sensor_nivel), .parar(parar),
        .valvula(valvula), .bomba_on(bomba_on), .zona_ativa(zona_ativa),
        .tempo_restante_ms(tempo_restante_ms), .ocupado(ocupado), .done(done),
        .alerta_nivel_baixo(alerta_nivel_baixo));

    irrigacao_multizona #(.N_ZONAS(4), .TEMPO_W(16), .CICLOS_MS(1), .T_ABRE_MS(1),
                          .NIVEL_MIN(20), .NIVEL_RETOMA(30)) dut_larg (
        .clk(clk), .rst(rst), .req(rif2.slave), .sensor_nivel(8'd80), .parar(1'b0),
        .valvula(valvula2), .bomba_on(bomba2), .zona_ativa(zona2),
        .tempo_restante_ms(rest2), .ocupado(ocupado2), .done(done2),
        .alerta_nivel_baixo(alerta2));

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [1:0]  zreq;
        logic [15:0] tempo;
        logic [7:0]  nivel;
        int          ncyc;
        logic [3:0]  e_valv;
        logic        e_bomba;
        logic [1:0]  e_zona;
        logic [15:0] e_rest;
        logic        e_ocup;
        logic [3:0]  e_done;
        logic [3:0]  e_ready;
        logic        e_alerta;
    } vec_t;

    vec_t tab[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic req(input logic [3:0] m, input logic [15:0] t);
        rif.req_valid    = m;
        rif.req_tempo_ms = {t, t, t, t};
    endtask

    function automatic logic [32:0] snap();
        return {valvula, bomba_on, zona_ativa, tempo_restante_ms, ocupado, done,
                rif.req_ready, alerta_nivel_baixo};
    endfunction

    initial begin
        int cnt;
        bit seen;
        rif.req_valid = '0;  rif.req_tempo_ms = '0;
        rif2.req_valid = '0; rif2.req_tempo_ms = '0;

        // vld zreq tempo nivel ncyc | valv bomba zona rest ocup done ready alerta
        tab.push_back('{1, 0, 3, 80, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1110, 0});
        tab.push_back('{0, 0, 0, 80, 1, 4'b0001, 0, 0, 3, 1, 4'b0000, 4'b1110, 0});
        tab.push_back('{0, 0, 0, 80, 3, 4'b0001, 0, 0, 3, 1, 4'b0000, 4'b1110, 0});
        tab.push_back('{0, 0, 0, 80, 1, 4'b0001, 1, 0, 3, 1, 4'b0000, 4'b1110, 0});
        tab.push_back('{0, 0, 0, 80, 3, 4'b0001, 1, 0, 3, 1, 4'b0000, 4'b1110, 0});
        tab.push_back('{0, 0, 0, 80, 1, 4'b0001, 1, 0, 2, 1, 4'b0000, 4'b1110, 0});
        tab.push_back('{0, 0, 0, 80, 4, 4'b0001, 1, 0, 1, 1, 4'b0000, 4'b1110, 0});
        tab.push_back('{0, 0, 0, 80, 3, 4'b0001, 1, 0, 1, 1, 4'b0000, 4'b1110, 0});
        tab.push_back('{0, 0, 0, 80, 1, 4'b0000, 0, 0, 0, 0, 4'b0001, 4'b1111, 0});
        tab.push_back('{0, 0, 0, 80, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1111, 0});
        // low level lands on a ms boundary, so pump time stays exactly 2 ms
        tab.push_back('{1, 2, 2, 80, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1011, 0});
        tab.push_back('{0, 0, 0, 80, 1, 4'b0100, 0, 2, 2, 1, 4'b0000, 4'b1011, 0});
        tab.push_back('{0, 0, 0, 80, 4, 4'b0100, 1, 2, 2, 1, 4'b0000, 4'b1011, 0});
        tab.push_back('{0, 0, 0, 80, 2, 4'b0100, 1, 2, 2, 1, 4'b0000, 4'b1011, 0});
        tab.push_back('{0, 0, 0, 10, 1, 4'b0100, 1, 2, 2, 1, 4'b0000, 4'b1011, 1});
        tab.push_back('{0, 0, 0, 10, 1, 4'b0100, 0, 2, 1, 1, 4'b0000, 4'b1011, 1});
        tab.push_back('{0, 0, 0, 25, 4, 4'b0100, 0, 2, 1, 1, 4'b0000, 4'b1011, 1});
        tab.push_back('{0, 0, 0, 35, 1, 4'b0100, 0, 2, 1, 1, 4'b0000, 4'b1011, 0});
        tab.push_back('{0, 0, 0, 35, 1, 4'b0100, 1, 2, 1, 1, 4'b0000, 4'b1011, 0});
        tab.push_back('{0, 0, 0, 80, 3, 4'b0100, 1, 2, 1, 1, 4'b0000, 4'b1011, 0});
        tab.push_back('{0, 0, 0, 80, 1, 4'b0000, 0, 0, 0, 0, 4'b0100, 4'b1111, 0});
        tab.push_back('{1, 1, 1, 10, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1101, 1});
        tab.push_back('{0, 0, 0, 10, 5, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1101, 1});
        tab.push_back('{0, 0, 0, 35, 1, 4'b0000, 0, 0, 0, 0, 4'b0000, 4'b1101, 0});
        tab.push_back('{0, 0, 0, 35, 1, 4'b0010, 0, 1, 1, 1, 4'b0000, 4'b1101, 0});
        tab.push_back('{0, 0, 0, 80, 4, 4'b0010, 1, 1, 1, 1, 4'b0000, 4'b1101, 0});
        tab.push_back('{0, 0, 0, 80, 4, 4'b0000, 0, 0, 0, 0, 4'b0010, 4'b1111, 0});

        step(); step();
        chk("reset_state", 64'(snap()), 64'({4'b0000, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b1111, 1'b0}));
        rst = 1'b0;
        step();

        foreach (tab[n]) begin
            sensor_nivel = tab[n].nivel;
            rif.req_valid = tab[n].vld ? (4'b0001 << tab[n].zreq) : 4'b0000;
            rif.req_tempo_ms = '0;
            rif.req_tempo_ms[tab[n].zreq*16 +: 16] = tab[n].tempo;
            step();
            rif.req_valid = '0;
            for (int c = 1; c < tab[n].ncyc; c++) step();
            chk($sformatf("vec%0d", n), 64'(snap()),
                64'({tab[n].e_valv, tab[n].e_bomba, tab[n].e_zona, tab[n].e_rest, tab[n].e_ocup,
                     tab[n].e_done, tab[n].e_ready, tab[n].e_alerta}));
        end

        // fairness from ptr=0
        sensor_nivel = 8'd80;
        rst = 1'b1; step(); rst = 1'b0;
        req(4'b1010, 16'd1); step(); req(4'b0000, 16'd0); step();
        chk("fair_first_z1", {zona_ativa, valvula}, {2'd1, 4'b0010});
        repeat (8) step();
        chk("fair_done_z1", done, 4'b0010);
        step();
        chk("fair_second_z3", {zona_ativa, valvula, ocupado}, {2'd3, 4'b1000, 1'b1});
        repeat (8) step();
        chk("fair_done_z3", done, 4'b1000);
        req(4'b1001, 16'd1); step(); req(4'b0000, 16'd0); step();
        chk("fair_wrap_z0", {zona_ativa, valvula}, {2'd0, 4'b0001});
        repeat (8) step();
        chk("fair_done_z0", done, 4'b0001);
        step();
        chk("fair_then_z3", {zona_ativa, valvula}, {2'd3, 4'b1000});
        repeat (8) step();
        chk("fair_done_z3b", done, 4'b1000);

        // handshake corners, held in IDLE by the low-level alert
        sensor_nivel = 8'd10; step(); step();
        req(4'b0100, 16'd5); step(); req(4'b0000, 16'd0);
        chk("hs_pending_not_ready", rif.req_ready, 4'b1011);
        req(4'b0100, 16'd9); step();
        req(4'b0010, 16'd0); step(); req(4'b0000, 16'd0);
        chk("hs_zero_tempo_ignored", rif.req_ready, 4'b1011);
        sensor_nivel = 8'd80; step(); step();
        chk("hs_tempo_kept", {zona_ativa, tempo_restante_ms}, {2'd2, 16'd5});
        req(4'b0100, 16'd7); step(); req(4'b0000, 16'd0);
        chk("hs_active_refused", rif.req_ready, 4'b1011);
        repeat (22) step();
        chk("hs_last_ms", {bomba_on, tempo_restante_ms}, {1'b1, 16'd1});
        step();
        chk("hs_done_z2", done, 4'b0100);
        step();
        chk("hs_nothing_queued", {ocupado, done}, {1'b0, 4'b0000});
        repeat (4) step();
        chk("hs_no_zero_done", {ocupado, done}, {1'b0, 4'b0000});

        // abort with another zone pending, then reset mid-pump
        req(4'b0011, 16'd3); step(); req(4'b0000, 16'd0); step();
        chk("ab_grant_z0", zona_ativa, 2'd0);
        repeat (6) step();
        chk("ab_pumping", bomba_on, 1'b1);
        parar = 1'b1; step(); parar = 1'b0;
        chk("ab_outputs_off", 64'(snap()), 64'({4'b0000, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b1101, 1'b0}));
        step();
        chk("ab_next_grant", 64'(snap()), 64'({4'b0010, 1'b0, 2'd1, 16'd3, 1'b1, 4'b0000, 4'b1101, 1'b0}));
        req(4'b1000, 16'd2); step(); req(4'b0000, 16'd0);
        repeat (4) step();
        chk("rst_pre_pump", {bomba_on, rif.req_ready}, {1'b1, 4'b0101});
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_pump", 64'(snap()), 64'({4'b0000, 1'b0, 2'd0, 16'd0, 1'b0, 4'b0000, 4'b1111, 1'b0}));
        repeat (10) step();
        chk("rst_queue_empty", {ocupado, valvula}, {1'b0, 4'b0000});

        // full-width request on the 1-cycle-per-ms instance
        rif2.req_valid = 4'b0001; rif2.req_tempo_ms = {48'd0, 16'hFFFF};
        step(); rif2.req_valid = '0; step();
        chk("w_load_ffff", rest2, 16'hFFFF);
        cnt = 0; seen = 1'b0;
        for (int c = 0; c < 70000; c++) begin
            step();
            if (bomba2) cnt++;
            if (done2[0]) begin seen = 1'b1; break; end
        end
        chk("w_done_seen", 64'(seen), 64'd1);
        chk("w_pump_cycles", cnt, 65535);
        chk("w_rest_zero", rest2, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
